// File: rtl/layer_mem_arbiter.sv
// layer_mem_arbiter
//   Round-robin arbiter and sequencer for the shared layer-memory port used by
//   the CNN layer engines (0 = conv writer, 1 = max-pool, 2 = flatten).
//   Issues at most one memory operation per cycle, registers every
//   memory-side signal and routes read data back to the issuing requester.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req/we              per-requester request and write(1)/read(0) flag
//   sel/addr/wdata      per-requester packed select [3i+2:3i], address, data
//   gnt                 one-hot grant (combinational)
//   rvalid/rdata        one-hot read return and broadcast read data
//   busy                command on the port or read still in flight
//   cwr/caddr_wr/cdata_wr, crd/caddr_rd, cdata_rd, csel   memory port
module layer_mem_arbiter #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 20,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [3*NREQ-1:0]        sel,
    input  logic [ADDR_W*NREQ-1:0]   addr,
    input  logic [DATA_W*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     cwr,
    output logic [ADDR_W-1:0]        caddr_wr,
    output logic [DATA_W-1:0]        cdata_wr,
    output logic                     crd,
    output logic [ADDR_W-1:0]        caddr_rd,
    input  logic [DATA_W-1:0]        cdata_rd,
    output logic [2:0]               csel
);

    localparam int unsigned PTR_W = (NREQ > 2) ? 2 : 1;

    // Registered state
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic                        cwr_q, cwr_d;
    logic                        crd_q, crd_d;
    logic [2:0]                  csel_q, csel_d;
    logic [ADDR_W-1:0]           caddr_wr_q, caddr_wr_d;
    logic [ADDR_W-1:0]           caddr_rd_q, caddr_rd_d;
    logic [DATA_W-1:0]           cdata_wr_q, cdata_wr_d;
    logic [NREQ-1:0]             rvalid_q, rvalid_d;
    logic [DATA_W-1:0]           rdata_q, rdata_d;
    logic                        busy_q, busy_d;
    // Stage k holds the one-hot owner of a read issued k cycles ago; stage 0
    // lines up with crd on the port, stage RD_LAT with cdata_rd being valid.
    logic [RD_LAT:0][NREQ-1:0]   tag_q, tag_d;

    // Arbitration results
    logic                        win_any;
    logic [PTR_W-1:0]            win_idx;
    logic [PTR_W-1:0]            cand;
    logic                        g_we;
    logic [2:0]                  g_sel;
    logic [ADDR_W-1:0]           g_addr;
    logic [DATA_W-1:0]           g_wdata;

    // Round-robin search from ptr; descending loop so the lowest offset wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr_q) + k) % int'(NREQ));
            if (req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
        gnt = win_any ? (NREQ'(1) << win_idx) : '0;
    end

    // Select the winning requester's command fields.
    always_comb begin
        g_we    = 1'b0;
        g_sel   = '0;
        g_addr  = '0;
        g_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                g_we    = we[i];
                g_sel   = sel[3*i +: 3];
                g_addr  = addr[ADDR_W*i +: ADDR_W];
                g_wdata = wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Next-state: command register, pointer, read-tag pipeline, return path.
    always_comb begin
        ptr_d      = ptr_q;
        cwr_d      = 1'b0;
        crd_d      = 1'b0;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        cdata_wr_d = cdata_wr_q;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        tag_d      = '0;

        // win_any already implies req, so it marks a completed handshake.
        if (win_any) begin
            ptr_d  = PTR_W'((int'(win_idx) + 1) % int'(NREQ));
            csel_d = g_sel;
            if (g_we) begin
                cwr_d      = 1'b1;
                caddr_wr_d = g_addr;
                cdata_wr_d = g_wdata;
            end else begin
                crd_d      = 1'b1;
                caddr_rd_d = g_addr;
                tag_d[0]   = gnt;
            end
        end

        for (int unsigned k = 1; k <= RD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        // Capture memory data while the oldest tag is at the data-valid stage.
        rvalid_d = tag_q[RD_LAT];
        if (|tag_q[RD_LAT]) begin
            rdata_d = cdata_rd;
        end

        // The rvalid cycle counts as part of the read still being in flight.
        busy_d = cwr_d | crd_d | (|rvalid_d) | (|tag_d);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= '0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            tag_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
            cdata_wr_q <= cdata_wr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            tag_q      <= tag_d;
        end
    end

    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Bench for layer_mem_arbiter: directed scenarios plus a randomized phase.
// A reference model predicts grants, port commands, read returns and busy;
// a separate monitor compares the DUT outputs against the queued predictions.
module tb_layer_mem_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam int RD_LAT = 1;
    localparam int KEY_W  = 3 + ADDR_W;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req, we;
    logic [3*NREQ-1:0]      sel;
    logic [ADDR_W*NREQ-1:0] addr;
    logic [DATA_W*NREQ-1:0] wdata;
    logic [NREQ-1:0]        gnt, rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   cwr, crd;
    logic [ADDR_W-1:0]      caddr_wr, caddr_rd;
    logic [DATA_W-1:0]      cdata_wr, cdata_rd;
    logic [2:0]             csel;

    layer_mem_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .sel(sel), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
        .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-requester stimulus
    logic              r_req   [NREQ];
    logic              r_we    [NREQ];
    logic [2:0]        r_sel   [NREQ];
    logic [ADDR_W-1:0] r_addr  [NREQ];
    logic [DATA_W-1:0] r_wdata [NREQ];
    bit                hs_flag [NREQ];

    always_comb begin
        req = '0; we = '0; sel = '0; addr = '0; wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i]                   = r_req[i];
            we[i]                    = r_we[i];
            sel[3*i +: 3]            = r_sel[i];
            addr[ADDR_W*i +: ADDR_W] = r_addr[i];
            wdata[DATA_W*i +: DATA_W] = r_wdata[i];
        end
    end

    // Memory contents (environment) and the model's view of it
    logic [DATA_W-1:0] env_mem   [logic [KEY_W-1:0]];
    logic [DATA_W-1:0] model_mem [logic [KEY_W-1:0]];
    logic [DATA_W-1:0] mpipe [RD_LAT];

    function automatic logic [DATA_W-1:0] init_val(logic [KEY_W-1:0] k);
        return DATA_W'((32'(k) * 32'd40503) ^ 32'h0005A5A5);
    endfunction

    function automatic logic [DATA_W-1:0] env_read(logic [KEY_W-1:0] k);
        return env_mem.exists(k) ? env_mem[k] : init_val(k);
    endfunction

    // Memory with RD_LAT cycles from sampled crd to valid cdata_rd
    always @(posedge clk) begin
        if (cwr) env_mem[{csel, caddr_wr}] = cdata_wr;
        for (int k = RD_LAT - 1; k > 0; k--) mpipe[k] <= mpipe[k-1];
        mpipe[0] <= crd ? env_read({csel, caddr_rd}) : DATA_W'($urandom);
    end
    assign cdata_rd = mpipe[RD_LAT-1];

    // Scoreboard queues
    typedef struct {
        int                cyc;
        bit                w;
        logic [2:0]        s;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } port_op_t;
    typedef struct {
        int                cyc;
        int                idx;
        logic [DATA_W-1:0] d;
    } rd_ret_t;

    port_op_t port_q[$];
    rd_ret_t  rd_q[$];

    int                m_ptr;
    int                busy_from, busy_until;
    logic [2:0]        last_sel;
    logic [ADDR_W-1:0] last_aw, last_ar;
    logic [DATA_W-1:0] last_dw, last_rd;

    task automatic clear_model();
        port_q.delete();
        rd_q.delete();
        m_ptr = 0;
        busy_from = 0;
        busy_until = -10;
        last_sel = '0; last_aw = '0; last_ar = '0; last_dw = '0; last_rd = '0;
        for (int i = 0; i < NREQ; i++) hs_flag[i] = 1'b0;
    endtask

    // Reference model: round-robin choice, port op one cycle after the
    // handshake, read return 2+RD_LAT cycles after it, busy intervals.
    always @(negedge clk) begin : model
        int g, c, e_cyc;
        logic [KEY_W-1:0] key;
        port_op_t op;
        rd_ret_t rr;
        if (!reset) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (g < 0 && r_req[c]) g = c;
            end
            check("gnt", 64'(gnt), (g < 0) ? 64'(0) : (64'(1) << g));
            for (int i = 0; i < NREQ; i++) hs_flag[i] = 1'b0;
            if (g >= 0) begin
                hs_flag[g] = 1'b1;
                m_ptr = (g + 1) % NREQ;
                key = {r_sel[g], r_addr[g]};
                op.cyc = cyc + 1; op.w = r_we[g]; op.s = r_sel[g];
                op.a = r_addr[g]; op.d = r_wdata[g];
                port_q.push_back(op);
                if (r_we[g]) begin
                    model_mem[key] = r_wdata[g];
                    e_cyc = cyc + 1;
                end else begin
                    rr.cyc = cyc + 2 + RD_LAT;
                    rr.idx = g;
                    rr.d = model_mem.exists(key) ? model_mem[key] : init_val(key);
                    rd_q.push_back(rr);
                    e_cyc = cyc + 2 + RD_LAT;
                end
                if (cyc + 1 > busy_until + 1) busy_from = cyc + 1;
                if (e_cyc > busy_until) busy_until = e_cyc;
            end
        end
    end

    // Monitor: compares the memory port, read return and busy each cycle.
    always @(negedge clk) begin : monitor
        port_op_t e;
        rd_ret_t r;
        if (!reset) begin
            check("cwr_crd_excl", 64'(cwr & crd), 64'(0));
            if (cwr || crd) begin
                if (port_q.size() == 0) begin
                    check("port_unexpected", 64'(1), 64'(0));
                end else begin
                    e = port_q.pop_front();
                    check("port_cycle", 64'(cyc), 64'(e.cyc));
                    check("cwr", 64'(cwr), 64'(e.w));
                    check("crd", 64'(crd), 64'(!e.w));
                    check("csel", 64'(csel), 64'(e.s));
                    last_sel = e.s;
                    if (e.w) begin
                        check("caddr_wr", 64'(caddr_wr), 64'(e.a));
                        check("cdata_wr", 64'(cdata_wr), 64'(e.d));
                        check("caddr_rd_hold", 64'(caddr_rd), 64'(last_ar));
                        last_aw = e.a;
                        last_dw = e.d;
                    end else begin
                        check("caddr_rd", 64'(caddr_rd), 64'(e.a));
                        check("caddr_wr_hold", 64'(caddr_wr), 64'(last_aw));
                        check("cdata_wr_hold", 64'(cdata_wr), 64'(last_dw));
                        last_ar = e.a;
                    end
                end
            end else begin
                if (port_q.size() != 0 && port_q[0].cyc <= cyc) begin
                    check("port_missing", 64'(1), 64'(0));
                    void'(port_q.pop_front());
                end
                check("csel_hold", 64'(csel), 64'(last_sel));
                check("caddr_wr_hold", 64'(caddr_wr), 64'(last_aw));
                check("caddr_rd_hold", 64'(caddr_rd), 64'(last_ar));
                check("cdata_wr_hold", 64'(cdata_wr), 64'(last_dw));
            end

            if (rvalid != '0) begin
                if (rd_q.size() == 0) begin
                    check("rvalid_unexpected", 64'(rvalid), 64'(0));
                end else begin
                    r = rd_q.pop_front();
                    check("rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    check("rvalid", 64'(rvalid), 64'(1) << r.idx);
                    check("rdata", 64'(rdata), 64'(r.d));
                    last_rd = r.d;
                end
            end else begin
                if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
                    check("rvalid_missing", 64'(1), 64'(0));
                    void'(rd_q.pop_front());
                end
                check("rdata_hold", 64'(rdata), 64'(last_rd));
            end

            check("busy", 64'(busy), 64'((cyc >= busy_from) && (cyc <= busy_until)));
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic new_op(int i);
        r_we[i]    = 1'($urandom_range(0, 1));
        r_sel[i]   = 3'($urandom_range(0, 7));
        r_addr[i]  = ADDR_W'($urandom_range(0, 15));
        r_wdata[i] = DATA_W'($urandom);
    endtask

    // Raise one request, hold it until the handshake edge, then drop it.
    task automatic issue(int i, bit w, logic [2:0] s, logic [ADDR_W-1:0] a,
                         logic [DATA_W-1:0] d);
        int n;
        n = 0;
        r_req[i] = 1'b1; r_we[i] = w; r_sel[i] = s; r_addr[i] = a; r_wdata[i] = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!hs_flag[i] && n < 20);
        check("grant_wait", 64'(hs_flag[i]), 64'(1));
        r_req[i] = 1'b0;
    endtask

    // All requesters request continuously; fresh command after each grant.
    task automatic contention(int n);
        for (int i = 0; i < NREQ; i++) begin
            new_op(i);
            r_req[i] = 1'b1;
        end
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) if (hs_flag[i]) new_op(i);
        end
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_cwr", 64'(cwr), 64'(0));
        check("rst_crd", 64'(crd), 64'(0));
        check("rst_csel", 64'(csel), 64'(0));
        check("rst_caddr_wr", 64'(caddr_wr), 64'(0));
        check("rst_caddr_rd", 64'(caddr_rd), 64'(0));
        check("rst_cdata_wr", 64'(cdata_wr), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_sel[i] = '0;
            r_addr[i] = '0; r_wdata[i] = '0;
        end
        clear_model();
        env_mem[{3'd3, 12'h005}]   = 20'h0ABCD;
        model_mem[{3'd3, 12'h005}] = 20'h0ABCD;

        reset = 1'b1;
        idle(3);
        check_reset_outputs();
        reset = 1'b0;
        idle(2);

        // Single write, then single read returning preloaded data
        issue(0, 1'b1, 3'd1, 12'h041, 20'h01234);
        idle(3);
        issue(1, 1'b0, 3'd3, 12'h005, 20'h0);
        idle(5);

        // Bring ptr back to 0, then full contention for 6 cycles
        issue(2, 1'b0, 3'd5, 12'h100, 20'h0);
        idle(5);
        contention(6);
        idle(5);

        // Write then read of the same location
        issue(0, 1'b1, 3'd1, 12'h010, 20'h00777);
        issue(1, 1'b0, 3'd1, 12'h010, 20'h0);
        idle(5);

        // Streaming reads at addresses 0..3
        for (int a = 0; a < 4; a++) issue(1, 1'b0, 3'd3, ADDR_W'(a), 20'h0);
        idle(6);

        // Reset with a read in flight
        issue(1, 1'b0, 3'd4, 12'h020, 20'h0);
        idle(1);
        reset = 1'b1;
        clear_model();
        #1;
        check_reset_outputs();
        idle(2);
        reset = 1'b0;
        contention(3);
        idle(6);

        // Randomized traffic; a pending request holds until granted
        repeat (600) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r_req[i] || hs_flag[i]) begin
                    if ($urandom_range(0, 99) < 55) begin
                        new_op(i);
                        r_req[i] = 1'b1;
                    end else begin
                        r_req[i] = 1'b0;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
        idle(10);

        check("port_drain", 64'(port_q.size()), 64'(0));
        check("read_drain", 64'(rd_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer_mem_arbiter.md
Name: layer_mem_arbiter

Overview:
- Round-robin arbiter and sequencer for the single shared layer-memory port (csel/crd/cwr) used by the CNN layer engines.
- Requesters: 0 = conv writer (layer 0, csel 1/2), 1 = max-pool reader/writer (layer 0 -> layer 1, csel 3/4), 2 = flatten (layer 1 -> layer 2, csel 5).
- Issues at most one memory operation per cycle, registers every memory-side signal, and routes read data back to the issuing requester after a fixed latency.

Parameters:
- NREQ, 3, number of requesters (2..4).
- ADDR_W, 12, memory address width.
- DATA_W, 20, memory data width.
- RD_LAT, 1, cycles from crd sampled high at the memory to cdata_rd valid (1..4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request.
- we  in  NREQ  per-requester 1 = write, 0 = read.
- sel  in  3*NREQ  per-requester memory select; requester i uses [3i+2:3i].
- addr  in  ADDR_W*NREQ  per-requester address.
- wdata  in  DATA_W*NREQ  per-requester write data.
- gnt  out  NREQ  one-hot grant, combinational.
- rvalid  out  NREQ  one-hot read-data-valid, registered.
- rdata  out  DATA_W  read data, broadcast to all requesters, valid with rvalid.
- busy  out  1  high while any read is in flight or any command is on the port.
- cwr  out  1  memory write strobe.
- caddr_wr  out  ADDR_W  write address.
- cdata_wr  out  DATA_W  write data.
- crd  out  1  memory read strobe.
- caddr_rd  out  ADDR_W  read address.
- cdata_rd  in  DATA_W  memory read data.
- csel  out  3  memory select.

Behaviour:
- Reset (async, any time):
  - cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, rvalid, rdata, busy all = 0.
  - Round-robin pointer ptr = 0.
  - Read-tag pipeline cleared; no rvalid is produced for reads in flight when reset hits.
- Arbitration (combinational):
  - Among asserted req bits, grant the first index found searching ptr, ptr+1, ... modulo NREQ.
  - gnt is one-hot or zero; gnt[i] is never high without req[i].
  - A handshake completes at the rising edge where req[i] & gnt[i].
  - The requester holds we/sel/addr/wdata stable while req is high and ungranted.
  - The requester may keep req high after a grant to issue back-to-back operations; it still competes each cycle.
- Pointer update: on a completed handshake by i, ptr <= (i+1) mod NREQ. With no handshake, ptr holds.
- Fairness: a continuously requesting requester waits at most NREQ-1 cycles for a grant.
- Command issue: handshake at edge T puts the command on the memory port in cycle T+1.
  - Write: cwr = 1, caddr_wr = addr, cdata_wr = wdata, csel = sel, crd = 0.
  - Read: crd = 1, caddr_rd = addr, csel = sel, cwr = 0.
  - cwr and crd are never high together.
  - With no handshake, cwr = crd = 0 next cycle; csel, caddr_*, cdata_wr hold their last values.
- Read return: for a read issued at port cycle T+1, rvalid[i] = 1 and rdata = cdata_rd (captured) in cycle T+2+RD_LAT-1+1, i.e. T+3 for RD_LAT = 1.
  - Requester i's index travels down an RD_LAT+1-deep tag shift register.
  - Back-to-back reads return in issue order, one per cycle.
  - rdata holds its last value when rvalid = 0.
- Ordering: operations reach the memory in handshake order. A write followed by a read to the same address returns the new data.
- busy = any bit of the tag pipeline set, or cwr, or crd.
- Out-of-range sel (0, 6, 7): forwarded unchanged. Checking is the requester's responsibility.

Test Plan:
- Single write: req = 001, we = 1, sel = 1, addr = 12'h041, wdata = 20'h01234 -> gnt = 001 same cycle; next cycle cwr = 1, csel = 1, caddr_wr = 041, cdata_wr = 01234; ptr = 1.
- Single read, RD_LAT = 1: req[1] read, sel = 3, addr = 12'h005; memory returns 20'h0ABCD -> crd = 1 at T+1; rvalid = 010, rdata = 0ABCD at T+3; busy high T+1..T+3.
- Contention: req = 111 held for 6 cycles from ptr = 0 -> grants 0,1,2,0,1,2; no cwr and crd overlap; each issued op matches its requester's address.
- Write-then-read same address: req0 writes 20'h00777 to csel 1 addr 0x010, then req1 reads the same -> rvalid[1] with rdata = 00777 (memory model).
- Streaming reads: req1 issues 4 consecutive reads at addr 0..3 -> rvalid[1] on 4 consecutive cycles, data in address order.
- Reset mid-flight: assert reset one cycle after a read handshake -> all outputs 0 immediately; no rvalid after reset release; next grant starts searching from requester 0.
